// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of the RV32I instruction encoder.
// The slave modport is the encoder; the master modport is whatever feeds fields and sinks words.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field bundles into instruction words with one output register.
// Define IMM_CHECK_EN to validate immediate ranges and replace violating instructions with NOP_WORD.
module instr_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int          BASE_ADDR = 0,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  instr_encoder_if.slave    bus,
  output logic              err_opcode,
  output logic              err_imm,
  output logic [ADDR_W-1:0] word_count
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              err_opcode_q, err_opcode_d;
  logic              err_imm_q, err_imm_d;

  logic [31:0] enc_word;
  logic [31:0] final_word;
  logic        bad_op;
  logic        imm_bad;
  logic        in_fire;
  logic        out_fire;

  logic [6:0]  op;
  logic [31:0] imm;
  logic [31:0] i_word;
  assign op     = bus.in_opcode;
  assign imm    = bus.in_imm;
  assign i_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, op};

  always_comb begin
    enc_word = NOP_WORD;
    bad_op   = 1'b0;
    imm_bad  = 1'b0;
    case (op)
      OP_R: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, op};
      OP_IMM: begin
        if (bus.in_funct3 == 3'b001 || bus.in_funct3 == 3'b101) begin
          enc_word = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, op};
`ifdef IMM_CHECK_EN
          imm_bad  = |imm[31:5];
`endif
        end else begin
          enc_word = i_word;
`ifdef IMM_CHECK_EN
          imm_bad  = (imm[31:11] != {21{imm[11]}});
`endif
        end
      end
      OP_LOAD, OP_JALR: begin
        enc_word = i_word;
`ifdef IMM_CHECK_EN
        imm_bad  = (imm[31:11] != {21{imm[11]}});
`endif
      end
      OP_STORE: begin
        enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], op};
`ifdef IMM_CHECK_EN
        imm_bad  = (imm[31:11] != {21{imm[11]}});
`endif
      end
      OP_BRANCH: begin
        enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    imm[4:1], imm[11], op};
`ifdef IMM_CHECK_EN
        imm_bad  = (imm[31:12] != {20{imm[12]}}) || imm[0];
`endif
      end
      OP_LUI, OP_AUIPC: begin
        enc_word = {imm[31:12], bus.in_rd, op};
`ifdef IMM_CHECK_EN
        imm_bad  = |imm[11:0];
`endif
      end
      OP_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, op};
`ifdef IMM_CHECK_EN
        imm_bad  = (imm[31:20] != {12{imm[20]}}) || imm[0];
`endif
      end
      default: bad_op = 1'b1;
    endcase
    final_word = (bad_op || imm_bad) ? NOP_WORD : enc_word;
  end

  // in_ready is forced low while reset is asserted so nothing is accepted then.
  assign bus.in_ready = rst_n && (!valid_q || bus.out_ready);
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = valid_q && bus.out_ready;

  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    addr_d       = addr_q;
    count_d      = count_q;
    err_opcode_d = err_opcode_q;
    err_imm_d    = err_imm_q;
    if (out_fire) begin
      valid_d = 1'b0;
      addr_d  = addr_q + ADDR_W'(4);
      count_d = count_q + ADDR_W'(1);
    end
    // restart overrides the address advance but leaves a held word in place
    if (restart) begin
      addr_d       = BASE;
      count_d      = '0;
      err_opcode_d = 1'b0;
      err_imm_d    = 1'b0;
    end
    if (in_fire) begin
      valid_d      = 1'b1;
      instr_d      = final_word;
      err_opcode_d = err_opcode_d | bad_op;
      err_imm_d    = err_imm_d | imm_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      instr_q      <= '0;
      addr_q       <= BASE;
      count_q      <= '0;
      err_opcode_q <= 1'b0;
      err_imm_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      err_opcode_q <= err_opcode_d;
      err_imm_q    <= err_imm_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = addr_q;
  assign err_opcode    = err_opcode_q;
  assign err_imm       = err_imm_q;
  assign word_count    = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, handshakes, restart and reset.
module tb_instr_encoder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       restart;
  logic       err_opcode;
  logic       err_imm;
  logic [9:0] word_count;

  int pass_cnt = 0;
  int check_cnt = 0;

  instr_encoder_if #(.ADDR_W(10)) bus ();

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0), .NOP_WORD(32'h0000_0013)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .bus        (bus.slave),
    .err_opcode (err_opcode),
    .err_imm    (err_imm),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm);
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    restart = 1'b0;
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    check_cnt++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_addr !== 10'd0) begin
      $display("FAIL reset_out: valid=%b instr=%h addr=%0d, want 0/00000000/0",
               bus.out_valid, bus.out_instr, bus.out_addr);
    end else pass_cnt++;
    check_cnt++;
    if (word_count !== 10'd0 || err_opcode !== 1'b0 || err_imm !== 1'b0) begin
      $display("FAIL reset_status: count=%0d err_op=%b err_imm=%b, want 0/0/0",
               word_count, err_opcode, err_imm);
    end else pass_cnt++;
    $display("reset: valid=%b addr=%0d count=%0d", bus.out_valid, bus.out_addr, word_count);
  endtask

  task automatic test_add();
    apply_reset();
    bus.out_ready = 1'b0;
    set_fields(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h002081B3 || bus.out_addr !== 10'd0) begin
      $display("FAIL add: valid=%b instr=%h addr=%0d, want 1/002081b3/0",
               bus.out_valid, bus.out_instr, bus.out_addr);
    end else pass_cnt++;
    $display("add: instr=%h addr=%0d", bus.out_instr, bus.out_addr);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [0:8];
    exp_w = '{32'hFFF00293, 32'h0020A423, 32'hFE208EE3, 32'h001000EF, 32'h12345537,
              32'h00311093, 32'h40315093, 32'h00001097, 32'h004100E7};
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: set_fields(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        1: set_fields(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        2: set_fields(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        3: set_fields(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        4: set_fields(7'b0110111, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        5: set_fields(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd1, 7'h00, 32'd3);
        6: set_fields(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3);
        7: set_fields(7'b0010111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
        default: set_fields(7'b1100111, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd4);
      endcase
      bus.in_valid = 1'b1;
      #1;
      check_cnt++;
      if (bus.in_ready !== 1'b1) begin
        $display("FAIL b2b_ready[%0d]: in_ready=%b, want 1", i, bus.in_ready);
      end else pass_cnt++;
      step();
      check_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== exp_w[i] ||
          bus.out_addr !== 10'(4 * i) || word_count !== 10'(i)) begin
        $display("FAIL b2b[%0d]: valid=%b instr=%h addr=%0d count=%0d, want 1/%h/%0d/%0d",
                 i, bus.out_valid, bus.out_instr, bus.out_addr, word_count, exp_w[i], 4 * i, i);
      end else pass_cnt++;
      $display("b2b[%0d]: instr=%h addr=%0d count=%0d", i, bus.out_instr, bus.out_addr, word_count);
    end
    bus.in_valid = 1'b0;
    step();
    check_cnt++;
    if (bus.out_valid !== 1'b0 || word_count !== 10'd9 || bus.out_addr !== 10'd36) begin
      $display("FAIL b2b_drain: valid=%b count=%0d addr=%0d, want 0/9/36",
               bus.out_valid, word_count, bus.out_addr);
    end else pass_cnt++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.out_ready = 1'b0;
    set_fields(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    bus.in_valid = 1'b1;
    step();
    set_fields(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      check_cnt++;
      if (bus.in_ready !== 1'b0 || bus.out_instr !== 32'h002081B3 || bus.out_addr !== 10'd0) begin
        $display("FAIL stall[%0d]: in_ready=%b instr=%h addr=%0d, want 0/002081b3/0",
                 i, bus.in_ready, bus.out_instr, bus.out_addr);
      end else pass_cnt++;
      $display("stall[%0d]: instr=%h addr=%0d", i, bus.out_instr, bus.out_addr);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check_cnt++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL release_ready: in_ready=%b, want 1", bus.in_ready);
    end else pass_cnt++;
    step();
    bus.in_valid = 1'b0;
    check_cnt++;
    if (bus.out_instr !== 32'hFFF00293 || bus.out_addr !== 10'd4 || word_count !== 10'd1) begin
      $display("FAIL release: instr=%h addr=%0d count=%0d, want fff00293/4/1",
               bus.out_instr, bus.out_addr, word_count);
    end else pass_cnt++;
    step();
    check_cnt++;
    if (bus.out_valid !== 1'b0 || bus.out_addr !== 10'd8 || word_count !== 10'd2) begin
      $display("FAIL release_drain: valid=%b addr=%0d count=%0d, want 0/8/2",
               bus.out_valid, bus.out_addr, word_count);
    end else pass_cnt++;
  endtask

  task automatic test_bad_opcode_restart();
    apply_reset();
    bus.out_ready = 1'b1;
    set_fields(7'b1111111, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check_cnt++;
    if (bus.out_instr !== 32'h00000013 || err_opcode !== 1'b1) begin
      $display("FAIL bad_op: instr=%h err_op=%b, want 00000013/1", bus.out_instr, err_opcode);
    end else pass_cnt++;
    step();
    check_cnt++;
    if (err_opcode !== 1'b1 || bus.out_addr !== 10'd4) begin
      $display("FAIL bad_op_sticky: err_op=%b addr=%0d, want 1/4", err_opcode, bus.out_addr);
    end else pass_cnt++;
    restart = 1'b1;
    step();
    restart = 1'b0;
    check_cnt++;
    if (err_opcode !== 1'b0 || bus.out_addr !== 10'd0 || word_count !== 10'd0) begin
      $display("FAIL restart: err_op=%b addr=%0d count=%0d, want 0/0/0",
               err_opcode, bus.out_addr, word_count);
    end else pass_cnt++;
    set_fields(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    bus.in_valid = 1'b1;
    step();
    // restart during an output handshake must leave the address at the base
    restart = 1'b1;
    set_fields(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    step();
    restart = 1'b0;
    bus.in_valid = 1'b0;
    check_cnt++;
    if (bus.out_addr !== 10'd0 || word_count !== 10'd0 || bus.out_instr !== 32'hFFF00293) begin
      $display("FAIL restart_wins: addr=%0d count=%0d instr=%h, want 0/0/fff00293",
               bus.out_addr, word_count, bus.out_instr);
    end else pass_cnt++;
    $display("restart: addr=%0d count=%0d", bus.out_addr, word_count);
    step();
  endtask

  task automatic test_imm_range();
    logic [31:0] exp_addi;
    logic [31:0] exp_beq;
    logic        exp_err;
`ifdef IMM_CHECK_EN
    exp_addi = 32'h00000013;
    exp_beq  = 32'h00000013;
    exp_err  = 1'b1;
`else
    exp_addi = 32'h80000013;
    exp_beq  = 32'h00208163;
    exp_err  = 1'b0;
`endif
    apply_reset();
    bus.out_ready = 1'b1;
    set_fields(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    bus.in_valid = 1'b1;
    step();
    check_cnt++;
    if (bus.out_instr !== exp_addi || err_imm !== exp_err) begin
      $display("FAIL imm_addi: instr=%h err_imm=%b, want %h/%b",
               bus.out_instr, err_imm, exp_addi, exp_err);
    end else pass_cnt++;
    restart = 1'b1;
    set_fields(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    step();
    restart = 1'b0;
    bus.in_valid = 1'b0;
    check_cnt++;
    if (bus.out_instr !== exp_beq || err_imm !== exp_err) begin
      $display("FAIL imm_beq: instr=%h err_imm=%b, want %h/%b",
               bus.out_instr, err_imm, exp_beq, exp_err);
    end else pass_cnt++;
    $display("imm: beq instr=%h err_imm=%b", bus.out_instr, err_imm);
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.out_ready = 1'b0;
    set_fields(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus.in_valid = 1'b1;
    step();
    check_cnt++;
    if (bus.out_valid !== 1'b1 || err_opcode !== 1'b1) begin
      $display("FAIL mid_setup: valid=%b err_op=%b, want 1/1", bus.out_valid, err_opcode);
    end else pass_cnt++;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_cnt++;
    if (bus.in_ready !== 1'b0) begin
      $display("FAIL mid_in_ready: in_ready=%b, want 0", bus.in_ready);
    end else pass_cnt++;
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check_cnt++;
    if (bus.out_valid !== 1'b0 || bus.out_addr !== 10'd0 || err_opcode !== 1'b0 ||
        bus.out_instr !== 32'h0 || word_count !== 10'd0) begin
      $display("FAIL mid_reset: valid=%b addr=%0d err_op=%b instr=%h count=%0d, want 0/0/0/0/0",
               bus.out_valid, bus.out_addr, err_opcode, bus.out_instr, word_count);
    end else pass_cnt++;
    $display("mid_reset: valid=%b addr=%0d", bus.out_valid, bus.out_addr);
  endtask

  initial begin
    rst_n = 1'b0;
    restart = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_fields(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_bad_opcode_restart();
    test_imm_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- RV32I instruction encoder: the producer side of the decoder's 32-bit instruction interface.
- Accepts instruction fields (opcode, rd, rs1, rs2, funct3, funct7, imm) over a valid/ready handshake and packs them into the format-specific word layout, including immediate scrambling.
- Emits word plus target address through a registered output stage. Used by the program loader and self-test bench to fill instruction memory.

Parameters:
- ADDR_W, 10, width of the instruction-memory byte address counter.
- BASE_ADDR, 0, address assigned to the first word after reset or restart.
- NOP_WORD, 32'h00000013, substitute word for rejected instructions (ADDI x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- restart  in  1  pulse: reload address counter to BASE_ADDR, clear sticky errors.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- in_opcode  in  7  instruction[6:0].
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R-type; shift-immediate upper bits).
- in_imm  in  32  signed immediate (byte offset for B/J; full value for U).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  memory writer accepts word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address for out_instr.
- err_opcode  out  1  sticky: unsupported opcode seen.
- err_imm  out  1  sticky: immediate out of range or misaligned (IMM_CHECK_EN only).
- word_count  out  ADDR_W  words emitted since reset/restart.

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_instr=0, out_addr=BASE_ADDR, word_count=0, err_opcode=0, err_imm=0. Reset applies mid-handshake; any pending word is discarded.
- Single output register; latency 1 cycle from in handshake to out_valid.
- in_ready = !out_valid || out_ready (combinational); in_ready is 0 during reset.
- Input handshake (in_valid && in_ready): register the encoded word; out_valid=1 next cycle.
- Output handshake (out_valid && out_ready): out_addr += 4, word_count += 1. Both wrap modulo 2^ADDR_W with no flag.
- Simultaneous in and out handshake: new word loads and address advances in the same cycle, giving full throughput with one word per cycle.
- While out_valid && !out_ready: out_instr and out_addr hold stable.
- restart: reloads out_addr and word_count and clears errors. It does not drop a held word; that word is re-addressed to BASE_ADDR. If restart coincides with an output handshake, restart wins: address = BASE_ADDR, not BASE_ADDR+4.
- Encoding by opcode:
  - 0110011 R: {f7,rs2,rs1,f3,rd,op}.
  - 0010011 I-ALU: {imm[11:0],rs1,f3,rd,op}. When f3=001 or 101 (shifts): {f7,imm[4:0],rs1,f3,rd,op}.
  - 0000011 and 1100111: I format.
  - 0100011 S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - 1100011 B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - 0110111 and 0010111 U: {imm[31:12],rd,op}.
  - 1101111 J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Unused fields for a format are ignored.
- Any other opcode: word = NOP_WORD, err_opcode set (sticky). The word is still emitted so address alignment is preserved.

Optional Feature:
- Macro IMM_CHECK_EN.
- Defined: immediate range is validated.
  - I/S: -2048..2047.
  - Shift-immediate: 0..31.
  - B: -4096..4094, bit0=0.
  - J: ±1 MiB, bit0=0.
  - U: imm[11:0]=0.
  - On violation: word = NOP_WORD, err_imm set (sticky).
- Undefined: no checks; immediate bits outside the format are silently truncated; err_imm tied to 0.

Test Plan:
- Reset, then ADD x3,x1,x2 (op 0110011, rd3, rs1 1, rs2 2, f3 0, f7 0) -> next cycle out_valid=1, out_instr=0x002081B3, out_addr=0.
- Back-to-back, out_ready=1:
  - ADDI x5,x0,-1 -> 0xFFF00293.
  - SW x2,8(x1) -> 0x0020A423.
  - BEQ x1,x2,-4 -> 0xFE208EE3.
  - JAL x1,2048 -> 0x001000EF.
  - LUI x10,0x12345000 -> 0x12345537.
  - Addresses 0,4,8,12,16; one word per cycle; word_count=5.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr/out_addr stable. Release -> single address advance of 4, no words lost or duplicated.
- Opcode 1111111 -> out_instr=0x00000013, err_opcode=1 and held. restart -> err_opcode=0, next out_addr=BASE_ADDR.
- With IMM_CHECK_EN: ADDI imm=2048 -> 0x00000013, err_imm=1; BEQ imm=3 -> NOP, err_imm=1. Without the macro: ADDI x0,x0,2048 -> 0x80000013, err_imm=0.
- rst_n low while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_addr=0, errors cleared.
